// File: rtl/sm3_msg_expnd.sv
// -----------------------------------------------------------------------------
// sm3_msg_expnd -- SM3 message expansion, 32-bit datapath (one round per beat).
//
// Loads one padded 512-bit block as 16 big-endian words (W0 first) over a
// valid/ready handshake. It then streams the 64 round pairs (W_j, W'_j) to the
// compression core, one pair per cycle, with no backpressure. The last-block
// flag is collected while loading and reported on round 63.
//
// Parameters:
//   OTPT_PIPE  0: outputs driven combinationally from the window
//              1: one register stage on wj/wjj/vld/lst (default)
//
// Optional build macro:
//   SM3_EXPND_BYTE_SWAP_EN  byte-reverse each accepted word (little-endian
//                           sources); ports and timing are unchanged
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   msg_inpt_d_i        message word
//   msg_inpt_vld_i      word valid
//   msg_inpt_lst_i      word belongs to the final block of the message
//   msg_inpt_rdy_o      stage can accept a word (high only while loading)
//   expnd_otpt_wj_o     W_j
//   expnd_otpt_wjj_o    W'_j = W_j ^ W_{j+4}
//   expnd_otpt_lst_o    round 63 of the last block
//   expnd_otpt_vld_o    round pair valid
// -----------------------------------------------------------------------------
module sm3_msg_expnd #(
    parameter int OTPT_PIPE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] msg_inpt_d_i,
    input  logic        msg_inpt_vld_i,
    input  logic        msg_inpt_lst_i,
    output logic        msg_inpt_rdy_o,
    output logic [31:0] expnd_otpt_wj_o,
    output logic [31:0] expnd_otpt_wjj_o,
    output logic        expnd_otpt_lst_o,
    output logic        expnd_otpt_vld_o
);

    typedef enum logic {LOAD = 1'b0, EXPND = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [15:0][31:0] win;         // win[0] is the oldest word, W_j in EXPND
    logic [3:0]        load_cntr;
    logic [5:0]        rnd_cntr;
    logic              lst_stky;

    logic [31:0] d_in;
    logic [31:0] w_new;
    logic        acc;
    logic        rnd_last;
    logic        c_vld, c_lst;
    logic [31:0] c_wj, c_wjj;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

`ifdef SM3_EXPND_BYTE_SWAP_EN
    assign d_in = {msg_inpt_d_i[7:0], msg_inpt_d_i[15:8],
                   msg_inpt_d_i[23:16], msg_inpt_d_i[31:24]};
`else
    assign d_in = msg_inpt_d_i;
`endif

    assign msg_inpt_rdy_o = (state == LOAD);
    assign acc            = (state == LOAD) && msg_inpt_vld_i;
    assign rnd_last       = (state == EXPND) && (rnd_cntr == 6'd63);

    // W_{j+16} from the current window, where win[k] holds W_{j+k}
    assign w_new = p1(win[0] ^ win[7] ^ rotl(win[13], 15)) ^ rotl(win[3], 7) ^ win[10];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (acc && load_cntr == 4'd15) state_nxt = EXPND;
            EXPND:   if (rnd_last)                  state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // ---------------- window / counters ----------------
    // Both counters clear by wrapping: load_cntr 15->0 on the 16th word and
    // rnd_cntr 63->0 on the final round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win       <= '0;
            load_cntr <= '0;
            rnd_cntr  <= '0;
            lst_stky  <= 1'b0;
        end else begin
            if (acc) begin
                win       <= {d_in, win[15:1]};
                load_cntr <= load_cntr + 4'd1;
                lst_stky  <= lst_stky | msg_inpt_lst_i;
            end
            if (state == EXPND) begin
                win      <= {w_new, win[15:1]};
                rnd_cntr <= rnd_cntr + 6'd1;
                if (rnd_last) lst_stky <= 1'b0;
            end
        end
    end

    // ---------------- outputs ----------------
    assign c_vld = (state == EXPND);
    assign c_wj  = win[0];
    assign c_wjj = win[0] ^ win[4];
    assign c_lst = rnd_last && lst_stky;

    generate
        if (OTPT_PIPE == 0) begin : g_comb
            assign expnd_otpt_vld_o = c_vld;
            assign expnd_otpt_lst_o = c_lst;
            assign expnd_otpt_wj_o  = c_wj;
            assign expnd_otpt_wjj_o = c_wjj;
        end else begin : g_reg
            logic        vld_q, lst_q;
            logic [31:0] wj_q, wjj_q;

            // data holds between bursts; only vld qualifies it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    lst_q <= 1'b0;
                    wj_q  <= '0;
                    wjj_q <= '0;
                end else begin
                    vld_q <= c_vld;
                    lst_q <= c_lst;
                    if (c_vld) begin
                        wj_q  <= c_wj;
                        wjj_q <= c_wjj;
                    end
                end
            end

            assign expnd_otpt_vld_o = vld_q;
            assign expnd_otpt_lst_o = lst_q;
            assign expnd_otpt_wj_o  = wj_q;
            assign expnd_otpt_wjj_o = wjj_q;
        end
    endgenerate

endmodule

// File: tb/tb_sm3_msg_expnd.sv
`timescale 1ns/1ps
module tb_sm3_msg_expnd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d = '0;
    logic        vld = 1'b0;
    logic        lst = 1'b0;

    logic        p1_rdy, p1_lst, p1_vld;
    logic [31:0] p1_wj, p1_wjj;
    logic        p0_rdy, p0_lst, p0_vld;
    logic [31:0] p0_wj, p0_wjj;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] wj;
        logic [31:0] wjj;
        logic        lst;
        int          cyc;
        int          bt;
        bit          abc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm3_msg_expnd #(.OTPT_PIPE(1)) u_p1 (
        .clk(clk), .rst_n(rst_n),
        .msg_inpt_d_i(d), .msg_inpt_vld_i(vld), .msg_inpt_lst_i(lst),
        .msg_inpt_rdy_o(p1_rdy),
        .expnd_otpt_wj_o(p1_wj), .expnd_otpt_wjj_o(p1_wjj),
        .expnd_otpt_lst_o(p1_lst), .expnd_otpt_vld_o(p1_vld)
    );

    sm3_msg_expnd #(.OTPT_PIPE(0)) u_p0 (
        .clk(clk), .rst_n(rst_n),
        .msg_inpt_d_i(d), .msg_inpt_vld_i(vld), .msg_inpt_lst_i(lst),
        .msg_inpt_rdy_o(p0_rdy),
        .expnd_otpt_wj_o(p0_wj), .expnd_otpt_wjj_o(p0_wjj),
        .expnd_otpt_lst_o(p0_lst), .expnd_otpt_vld_o(p0_vld)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    // drive words so the DUT sees the intended big-endian value after its swap
    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef SM3_EXPND_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] pp1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    // reference expansion, textbook recurrence over a flat W[] array
    task automatic push_block(input logic [31:0] m[16], input bit blst, input int a, input bit abc);
        logic [31:0] w[68];
        exp_t e;
        for (int j = 0; j < 16; j++) w[j] = m[j];
        for (int j = 16; j < 68; j++)
            w[j] = pp1(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
        for (int j = 0; j < 64; j++) begin
            e.wj = w[j]; e.wjj = w[j] ^ w[j+4]; e.lst = blst && (j == 63);
            e.bt = j; e.abc = abc;
            e.cyc = a + 1 + j; q1.push_back(e);
            e.cyc = a + j;     q0.push_back(e);
        end
    endtask

    // send 16 words; a = index of the edge that accepts the 16th word
    task automatic send_block(input logic [31:0] m[16], input logic [15:0] lmask,
                              input bit gaps, input bit abc, output int a);
        a = 0;
        for (int i = 0; i < 16; i++) begin
            int g;
            int t;
            if (gaps) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    @(negedge clk); #2;
                    vld = 1'b0; d = $urandom; lst = 1'($urandom_range(0, 1));
                end
            end
            t = 0;
            do begin
                @(negedge clk); #2;
                d = sw(m[i]); lst = lmask[i]; vld = 1'b1; t++;
            end while (!p1_rdy && t < 200);
            if (!p1_rdy) begin
                chk("rdy_wait_timeout", p1_rdy, 1);
                vld = 1'b0;
                return;
            end
            if (i == 15) begin
                a = cyc + 1;
                push_block(m, |lmask, a, abc);
            end
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk); #2;
        vld = 1'b0; lst = 1'b0;
    endtask

    // during EXPND, present junk words (with lst set) that must not be taken
    task automatic expnd_watch();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); #2;
            vld = 1'b1; d = $urandom; lst = 1'b1;
            chk($sformatf("expnd_rdy_p1_%0d", i), p1_rdy, 0);
            chk($sformatf("expnd_rdy_p0_%0d", i), p0_rdy, 0);
        end
        @(negedge clk); #2;
        vld = 1'b0; lst = 1'b0;
        chk("rdy_back_p1", p1_rdy, 1);
        chk("rdy_back_p0", p0_rdy, 1);
    endtask

    task automatic drain();
        int t = 0;
        while ((q1.size() != 0 || q0.size() != 0) && t < 400) begin
            @(negedge clk); t++;
        end
        repeat (4) @(negedge clk);
        chk("drain_q1_left", q1.size(), 0);
        chk("drain_q0_left", q0.size(), 0);
        q1.delete(); q0.delete();
    endtask

    task automatic beat(input string tag, input exp_t e, input logic [31:0] wj,
                        input logic [31:0] wjj, input logic l);
        chk($sformatf("%s_wj_b%0d", tag, e.bt), wj, e.wj);
        chk($sformatf("%s_wjj_b%0d", tag, e.bt), wjj, e.wjj);
        chk($sformatf("%s_lst_b%0d", tag, e.bt), l, e.lst);
        chk($sformatf("%s_cyc_b%0d", tag, e.bt), cyc, e.cyc);
        if (e.abc) begin
            if (e.bt == 0) begin
                chk({tag, "_abc_wj0"}, wj, 32'h61626380);
                chk({tag, "_abc_wjj0"}, wjj, 32'h61626380);
            end
            if (e.bt == 12) chk({tag, "_abc_wjj12"}, wjj, 32'h9092e200);
            if (e.bt == 16) chk({tag, "_abc_wj16"}, wj, 32'h9092e200);
            if (e.bt == 18) chk({tag, "_abc_wj18"}, wj, 32'h000c0606);
        end
    endtask

    always @(negedge clk) begin
        if (p1_vld) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL p1_extra_vld: got vld=1 at cyc %0d want 0", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                beat("p1", e, p1_wj, p1_wjj, p1_lst);
            end
        end else if (p1_lst) begin
            n_vec++; n_err++;
            $display("FAIL p1_lst_no_vld: got lst=1 at cyc %0d want 0", cyc);
        end
    end

    always @(negedge clk) begin
        if (p0_vld) begin
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL p0_extra_vld: got vld=1 at cyc %0d want 0", cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                beat("p0", e, p0_wj, p0_wjj, p0_lst);
            end
        end else if (p0_lst) begin
            n_vec++; n_err++;
            $display("FAIL p0_lst_no_vld: got lst=1 at cyc %0d want 0", cyc);
        end
    end

    initial begin
        logic [31:0] abc[16];
        logic [31:0] rnd[16];
        int a;
        for (int i = 0; i < 16; i++) begin
            abc[i] = 32'h0;
            rnd[i] = $urandom;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_p1_vld", p1_vld, 0);
        chk("rst_p1_lst", p1_lst, 0);
        chk("rst_p1_wj", p1_wj, 0);
        chk("rst_p1_wjj", p1_wjj, 0);
        chk("rst_p1_rdy", p1_rdy, 1);
        chk("rst_p0_vld", p0_vld, 0);
        chk("rst_p0_lst", p0_lst, 0);
        chk("rst_p0_wj", p0_wj, 0);
        chk("rst_p0_rdy", p0_rdy, 1);
        #2 rst_n = 1'b1;

        // "abc", last block, junk presented during EXPND
        send_block(abc, 16'hffff, 1'b0, 1'b1, a);
        expnd_watch();
        drain();

        // two-block message, lst only on one word of block 2
        send_block(rnd, 16'h0000, 1'b0, 1'b0, a);
        send_block(abc, 16'h0020, 1'b0, 1'b1, a);
        idle();
        drain();

        // random input gaps during LOAD
        send_block(abc, 16'hffff, 1'b1, 1'b1, a);
        idle();
        drain();

        // reset at beat 30 of the registered stream
        send_block(abc, 16'hffff, 1'b0, 1'b1, a);
        vld = 1'b0;
        repeat (32) @(negedge clk);
        #2 rst_n = 1'b0;
        q1.delete(); q0.delete();
        #1;
        chk("midrst_p1_vld", p1_vld, 0);
        chk("midrst_p0_vld", p0_vld, 0);
        chk("midrst_p1_lst", p1_lst, 0);
        chk("midrst_p1_rdy", p1_rdy, 1);
        chk("midrst_p0_rdy", p0_rdy, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        // sticky must be clear: a non-last block must not raise lst
        send_block(rnd, 16'h0000, 1'b0, 1'b0, a);
        idle();
        drain();
        send_block(abc, 16'hffff, 1'b0, 1'b1, a);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
